// File: rtl/resp_capture_if.sv
// Read-side handshake bundle of resp_capture: show-ahead head entry with valid/ready.
interface resp_capture_if #(
    parameter int SIG_W = 2,
    parameter int PC_W  = 32
);
    logic             rd_valid;
    logic             rd_ready;
    logic [SIG_W-1:0] rd_sig;
    logic [PC_W-1:0]  rd_pc;

    modport master (output rd_valid, output rd_sig, output rd_pc, input rd_ready);
    modport slave  (input rd_valid, input rd_sig, input rd_pc, output rd_ready);
endinterface

// File: rtl/resp_capture.sv
// Samples a signal vector per enabled cycle, tags it with a cycle index and buffers it in a show-ahead FIFO.
// Optional RESP_CAPTURE_DELTA_EN: only record samples that differ from the previous qualified sample.
module resp_capture #(
    parameter int SIG_W  = 2,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int PC_W   = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cap_en,
    input  logic [SIG_W-1:0]    sig_in,
    resp_capture_if.master      rd,
    output logic [ADDR_W:0]     count,
    output logic                full,
    output logic                drop,
    output logic [7:0]          drop_cnt
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [PC_W+SIG_W-1:0] mem [DEPTH];
    logic [PC_W+SIG_W-1:0] head;
    logic [PC_W-1:0]       pc_cnt;
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic                  qual;
    logic                  push;
    logic                  pop;
    logic                  lose;

`ifdef RESP_CAPTURE_DELTA_EN
    logic [SIG_W-1:0] last_sig;
    logic             have_last;
    assign qual = cap_en && (!have_last || (sig_in != last_sig));
`else
    assign qual = cap_en;
`endif

    assign full        = (count == DEPTH_C);
    assign rd.rd_valid = (count != '0);
    assign pop         = rd.rd_valid && rd.rd_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push        = qual && (!full || pop);
    assign lose        = qual && full && !pop;

    assign head        = mem[rd_ptr];
    assign rd.rd_sig   = rd.rd_valid ? head[SIG_W-1:0] : '0;
    assign rd.rd_pc    = rd.rd_valid ? head[PC_W+SIG_W-1:SIG_W] : '0;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {pc_cnt, sig_in};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_cnt    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            drop      <= 1'b0;
            drop_cnt  <= '0;
`ifdef RESP_CAPTURE_DELTA_EN
            last_sig  <= '0;
            have_last <= 1'b0;
`endif
        end else begin
            if (cap_en) pc_cnt <= pc_cnt + PC_W'(1);
            if (push)   wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)    rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
            if (lose) begin
                drop <= 1'b1;
                if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
`ifdef RESP_CAPTURE_DELTA_EN
            // Reference value tracks every qualified sample, including dropped ones.
            if (qual) begin
                last_sig  <= sig_in;
                have_last <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_resp_capture.sv
// Directed bench for resp_capture: a vector table plus hand sequences for overflow, reset and delta filtering.
module tb_resp_capture;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cap_en = 1'b0;
    logic [1:0] sig_in = 2'b00;
    logic [4:0] count;
    logic       full;
    logic       drop;
    logic [7:0] drop_cnt;
    int         nerr = 0;
    int         nchk = 0;

    resp_capture_if #(.SIG_W(2), .PC_W(32)) rd_if ();

    resp_capture #(.SIG_W(2), .DEPTH(16), .ADDR_W(4), .PC_W(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .cap_en   (cap_en),
        .sig_in   (sig_in),
        .rd       (rd_if),
        .count    (count),
        .full     (full),
        .drop     (drop),
        .drop_cnt (drop_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit         rst;
        bit         cap;
        logic [1:0] sig;
        bit         rdy;
        bit         e_valid;
        logic [1:0] e_sig;
        int         e_pc;
        int         e_count;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input bit cap, input logic [1:0] sig, input bit rdy,
                       input bit ev, input logic [1:0] es, input int epc, input int ecnt);
        vec_t v;
        v.rst = rst; v.cap = cap; v.sig = sig; v.rdy = rdy;
        v.e_valid = ev; v.e_sig = es; v.e_pc = epc; v.e_count = ecnt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input bit cap, input logic [1:0] sig, input bit rdy);
        cap_en = cap;
        sig_in = sig;
        rd_if.rd_ready = rdy;
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #3;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] dseq [8];
        int         exp_pc [$];
        int         exp_sg [$];
        int         p;

        rd_if.rd_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("reset_valid", rd_if.rd_valid, 0);
        chk("reset_count", count, 0);
        chk("reset_full", full, 0);
        chk("reset_drop", drop, 0);
        chk("reset_drop_cnt", drop_cnt, 0);
        chk("reset_rd_sig", rd_if.rd_sig, 0);
        chk("reset_rd_pc", rd_if.rd_pc, 0);

        // rst cap sig rdy | valid sig pc count (state after the edge)
        add(1, 1, 2'd1, 0, 1, 2'd1, 0, 1);
        add(0, 1, 2'd2, 0, 1, 2'd1, 0, 2);
        add(0, 1, 2'd3, 0, 1, 2'd1, 0, 3);
        add(0, 0, 2'd0, 1, 1, 2'd2, 1, 2);
        add(0, 0, 2'd0, 1, 1, 2'd3, 2, 1);
        add(0, 0, 2'd0, 1, 0, 2'd0, 0, 0);
        add(0, 0, 2'd0, 1, 0, 2'd0, 0, 0);
        add(1, 1, 2'd1, 1, 1, 2'd1, 0, 1);
        add(0, 0, 2'd0, 1, 0, 2'd0, 0, 0);
        add(0, 1, 2'd2, 1, 1, 2'd2, 1, 1);
        add(0, 0, 2'd0, 1, 0, 2'd0, 0, 0);
        add(0, 1, 2'd3, 1, 1, 2'd3, 2, 1);
        add(0, 0, 2'd0, 1, 0, 2'd0, 0, 0);
        add(0, 1, 2'd1, 0, 1, 2'd1, 3, 1);
        add(0, 1, 2'd2, 1, 1, 2'd2, 4, 1);
        add(0, 0, 2'd0, 1, 0, 2'd0, 0, 0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) pulse_reset();
            step(vecs[i].cap, vecs[i].sig, vecs[i].rdy);
            chk($sformatf("vec%0d_valid", i), rd_if.rd_valid, vecs[i].e_valid);
            chk($sformatf("vec%0d_sig", i), rd_if.rd_sig, vecs[i].e_sig);
            chk($sformatf("vec%0d_pc", i), rd_if.rd_pc, vecs[i].e_pc);
            chk($sformatf("vec%0d_count", i), count, vecs[i].e_count);
            chk($sformatf("vec%0d_drop", i), drop, 0);
        end

        // Overflow: 20 pushes into 16 entries, then push+pop while full, then drain.
        pulse_reset();
        for (int i = 0; i < 20; i++) begin
            step(1, 2'(i), 0);
            if (i == 14) chk("ovf_not_full_15", full, 0);
            if (i == 15) begin
                chk("ovf_full_16", full, 1);
                chk("ovf_nodrop_16", drop, 0);
            end
        end
        chk("ovf_count", count, 16);
        chk("ovf_drop", drop, 1);
        chk("ovf_drop_cnt", drop_cnt, 4);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fullpp_head%0d", i), rd_if.rd_pc, i);
            step(1, 2'(20 + i), 1);
            chk($sformatf("fullpp_count%0d", i), count, 16);
            chk($sformatf("fullpp_dcnt%0d", i), drop_cnt, 4);
        end
        chk("fullpp_head_after", rd_if.rd_pc, 5);
        for (int k = 0; k < 16; k++) begin
            p = (k < 11) ? 5 + k : 20 + (k - 11);
            chk($sformatf("drain_valid%0d", k), rd_if.rd_valid, 1);
            chk($sformatf("drain_pc%0d", k), rd_if.rd_pc, p);
            chk($sformatf("drain_sig%0d", k), rd_if.rd_sig, p % 4);
            step(0, 2'd0, 1);
        end
        chk("drain_empty", rd_if.rd_valid, 0);
        chk("drain_drop_sticky", drop, 1);

        // Drop counter saturation, then asynchronous mid-cycle reset.
        pulse_reset();
        for (int i = 0; i < 276; i++) step(1, 2'(i), 0);
        chk("sat_drop_cnt", drop_cnt, 255);
        chk("sat_count", count, 16);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", rd_if.rd_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_full", full, 0);
        chk("arst_drop", drop, 0);
        chk("arst_drop_cnt", drop_cnt, 0);
        #2;
        reset = 1'b1;
        step(1, 2'd3, 0);
        chk("arst_next_pc", rd_if.rd_pc, 0);
        chk("arst_next_sig", rd_if.rd_sig, 3);
        chk("arst_next_count", count, 1);

        // Change-only capture sequence.
        pulse_reset();
        dseq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd0};
        for (int i = 0; i < 8; i++) step(1, dseq[i], 0);
`ifdef RESP_CAPTURE_DELTA_EN
        exp_pc = '{0, 2, 5, 7};
        exp_sg = '{0, 1, 3, 0};
`else
        exp_pc = '{0, 1, 2, 3, 4, 5, 6, 7};
        exp_sg = '{0, 0, 1, 1, 1, 3, 3, 0};
`endif
        chk("delta_count", count, exp_pc.size());
        foreach (exp_pc[k]) begin
            chk($sformatf("delta_pc%0d", k), rd_if.rd_pc, exp_pc[k]);
            chk($sformatf("delta_sig%0d", k), rd_if.rd_sig, exp_sg[k]);
            step(0, 2'd0, 1);
        end
        chk("delta_empty", rd_if.rd_valid, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
